// File: rtl/dma_read_engine_if.sv
// Command, RQ request, RC completion and read-data stream signals of the DMA read engine.
interface dma_read_engine_if #(
  parameter int unsigned DATA_WIDTH = 256
);
  localparam int unsigned KW = DATA_WIDTH / 32;

  logic [15:0]           cfg_completer_id;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [63:0]           cmd_addr;
  logic [10:0]           cmd_len_dw;

  logic                  rq_ready;
  logic                  rq_valid;
  logic                  rq_is_write;
  logic                  rq_is_read;
  logic                  rq_sop;
  logic                  rq_last;
  logic [63:0]           rq_addr;
  logic [10:0]           rq_dword_count;
  logic [7:0]            rq_tag;
  logic [15:0]           rq_requester_id;
  logic [2:0]            rq_tc;
  logic [2:0]            rq_attr;
  logic [DATA_WIDTH-1:0] rq_payload;
  logic [KW-1:0]         rq_payload_keep;

  logic                  rc_desc_valid;
  logic [7:0]            rc_tag;
  logic [2:0]            rc_status;
  logic [10:0]           rc_dword_count;
  logic                  rc_request_completed;
  logic [3:0]            rc_error_code;
  logic                  rc_data_valid;
  logic                  rc_data_sop;
  logic                  rc_data_eop;
  logic [DATA_WIDTH-1:0] rc_payload;
  logic [KW-1:0]         rc_payload_keep;

  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [KW-1:0]         rd_data_keep;
  logic                  rd_data_last;

  logic                  done;
  logic [2:0]            err_code;
  logic                  busy;

  // Side that drives commands, RQ flow control and completions.
  modport master (
    output cfg_completer_id, cmd_valid, cmd_addr, cmd_len_dw, rq_ready,
    output rc_desc_valid, rc_tag, rc_status, rc_dword_count, rc_request_completed,
    output rc_error_code, rc_data_valid, rc_data_sop, rc_data_eop, rc_payload,
    output rc_payload_keep,
    input  cmd_ready, rq_valid, rq_is_write, rq_is_read, rq_sop, rq_last, rq_addr,
    input  rq_dword_count, rq_tag, rq_requester_id, rq_tc, rq_attr, rq_payload,
    input  rq_payload_keep, rd_data_valid, rd_data, rd_data_keep, rd_data_last,
    input  done, err_code, busy
  );

  // The read engine itself.
  modport slave (
    input  cfg_completer_id, cmd_valid, cmd_addr, cmd_len_dw, rq_ready,
    input  rc_desc_valid, rc_tag, rc_status, rc_dword_count, rc_request_completed,
    input  rc_error_code, rc_data_valid, rc_data_sop, rc_data_eop, rc_payload,
    input  rc_payload_keep,
    output cmd_ready, rq_valid, rq_is_write, rq_is_read, rq_sop, rq_last, rq_addr,
    output rq_dword_count, rq_tag, rq_requester_id, rq_tc, rq_attr, rq_payload,
    output rq_payload_keep, rd_data_valid, rd_data, rd_data_keep, rd_data_last,
    output done, err_code, busy
  );
endinterface

// File: rtl/dma_read_engine.sv
// Host-memory DMA read initiator: splits a read command into 4 KB-safe, MRRS-sized memory
// read requests (one outstanding), checks completions and streams payload in address order.
module dma_read_engine #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned MAX_REQ_DW     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              rst,
  dma_read_engine_if.slave io_bus
);
  localparam int unsigned KW = DATA_WIDTH / 32;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [10:0] MaxDw = 11'(MAX_REQ_DW);

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrBadCmd  = 3'd1;
  localparam logic [2:0] ErrStatus  = 3'd2;
  localparam logic [2:0] ErrCplErr  = 3'd3;
  localparam logic [2:0] ErrTag     = 3'd4;
  localparam logic [2:0] ErrTimeout = 3'd5;
  localparam logic [2:0] ErrLength  = 3'd6;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitCpl} state_e;

  state_e                r_state, w_state_nxt;
  logic [63:0]           r_next_addr, w_next_addr_nxt;
  logic [10:0]           r_total_rem, w_total_rem_nxt;
  logic [10:0]           r_cpl_rem, w_cpl_rem_nxt;
  logic [7:0]            r_tag_cnt, w_tag_cnt_nxt;
  logic [7:0]            r_out_tag, w_out_tag_nxt;
  logic                  r_cpl_flag, w_cpl_flag_nxt;
  logic [TW-1:0]         r_timer, w_timer_nxt;

  logic                  r_rq_valid, w_rq_valid_nxt;
  logic [63:0]           r_rq_addr, w_rq_addr_nxt;
  logic [10:0]           r_rq_dw, w_rq_dw_nxt;
  logic [7:0]            r_rq_tag, w_rq_tag_nxt;
  logic [15:0]           r_rq_req_id, w_rq_req_id_nxt;

  logic                  r_rd_valid, w_rd_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic [KW-1:0]         r_rd_keep, w_rd_keep_nxt;
  logic                  r_rd_last, w_rd_last_nxt;
  logic                  r_done, w_done_nxt;
  logic [2:0]            r_err, w_err_nxt;

  logic                  w_cmd_ready;
  logic                  w_cmd_bad;
  logic [10:0]           w_bound;
  logic [10:0]           w_chunk;
  logic [10:0]           w_beat_dw;
  logic [10:0]           w_rem_after;
  logic                  w_cpl_flag;
  logic [2:0]            w_beat_err;
  logic                  w_unused;

  assign w_cmd_ready = (r_state == StIdle) && !rst;
  assign w_cmd_bad   = (io_bus.cmd_len_dw == 11'd0) || (io_bus.cmd_len_dw > 11'd1024) ||
                       (io_bus.cmd_addr[1:0] != 2'b00);

  // Chunk = min(remaining, MRRS, DWords left before the next 4 KB boundary).
  always_comb begin
    w_bound = 11'd1024 - {1'b0, r_next_addr[11:2]};
    w_chunk = r_total_rem;
    if (MaxDw < w_chunk) w_chunk = MaxDw;
    if (w_bound < w_chunk) w_chunk = w_bound;
  end

  // DWords carried by the current completion beat (payload is packed from lane 0).
  always_comb begin
    w_beat_dw = '0;
    for (int i = 0; i < int'(KW); i++) begin
      w_beat_dw = w_beat_dw + 11'(io_bus.rc_payload_keep[i]);
    end
  end

  // Completion beat checks. request_completed arrives with the descriptor on the sop beat but
  // is only meaningful at the completion's eop, so it is held across the beats in between.
  always_comb begin
    w_cpl_flag  = io_bus.rc_desc_valid ? io_bus.rc_request_completed : r_cpl_flag;
    w_rem_after = r_cpl_rem - w_beat_dw;
    if (io_bus.rc_desc_valid && (io_bus.rc_tag != r_out_tag)) begin
      w_beat_err = ErrTag;
    end else if (io_bus.rc_desc_valid && (io_bus.rc_status != 3'd0)) begin
      w_beat_err = ErrStatus;
    end else if (io_bus.rc_desc_valid && (io_bus.rc_error_code != 4'd0)) begin
      w_beat_err = ErrCplErr;
    end else if (w_beat_dw > r_cpl_rem) begin
      w_beat_err = ErrLength;
    end else if (io_bus.rc_data_eop && w_cpl_flag && (w_rem_after != 11'd0)) begin
      w_beat_err = ErrLength;
    end else begin
      w_beat_err = ErrNone;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_next_addr_nxt = r_next_addr;
    w_total_rem_nxt = r_total_rem;
    w_cpl_rem_nxt   = r_cpl_rem;
    w_tag_cnt_nxt   = r_tag_cnt;
    w_out_tag_nxt   = r_out_tag;
    w_cpl_flag_nxt  = r_cpl_flag;
    w_timer_nxt     = r_timer;
    w_rq_valid_nxt  = 1'b0;
    w_rq_addr_nxt   = r_rq_addr;
    w_rq_dw_nxt     = r_rq_dw;
    w_rq_tag_nxt    = r_rq_tag;
    w_rq_req_id_nxt = r_rq_req_id;
    w_rd_valid_nxt  = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    w_rd_keep_nxt   = r_rd_keep;
    w_rd_last_nxt   = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = ErrNone;

    unique case (r_state)
      StIdle: begin
        if (io_bus.cmd_valid && w_cmd_ready) begin
          if (w_cmd_bad) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = ErrBadCmd;
          end else begin
            w_next_addr_nxt = io_bus.cmd_addr;
            w_total_rem_nxt = io_bus.cmd_len_dw;
            w_state_nxt     = StIssue;
          end
        end
      end
      StIssue: begin
        if (io_bus.rq_ready) begin
          w_rq_valid_nxt  = 1'b1;
          w_rq_addr_nxt   = r_next_addr;
          w_rq_dw_nxt     = w_chunk;
          w_rq_tag_nxt    = r_tag_cnt;
          w_rq_req_id_nxt = io_bus.cfg_completer_id;
          w_cpl_rem_nxt   = w_chunk;
          w_next_addr_nxt = r_next_addr + {51'b0, w_chunk, 2'b00};
          w_total_rem_nxt = r_total_rem - w_chunk;
          w_out_tag_nxt   = r_tag_cnt;
          w_tag_cnt_nxt   = r_tag_cnt + 8'd1;
          w_cpl_flag_nxt  = 1'b0;
          w_timer_nxt     = '0;
          w_state_nxt     = StWaitCpl;
        end
      end
      StWaitCpl: begin
        if (io_bus.rc_data_valid) begin
          if (w_beat_err != ErrNone) begin
            // Abandon the command; the offending beat is not forwarded.
            w_done_nxt  = 1'b1;
            w_err_nxt   = w_beat_err;
            w_state_nxt = StIdle;
          end else begin
            w_rd_valid_nxt = 1'b1;
            w_rd_data_nxt  = io_bus.rc_payload;
            w_rd_keep_nxt  = io_bus.rc_payload_keep;
            w_cpl_rem_nxt  = w_rem_after;
            w_cpl_flag_nxt = w_cpl_flag;
            w_timer_nxt    = '0;
            if (io_bus.rc_data_eop && (w_rem_after == 11'd0)) begin
              if (r_total_rem != 11'd0) begin
                w_state_nxt = StIssue;
              end else begin
                w_rd_last_nxt = 1'b1;
                w_done_nxt    = 1'b1;
                w_state_nxt   = StIdle;
              end
            end
          end
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = ErrTimeout;
          w_state_nxt = StIdle;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_next_addr <= '0;
      r_total_rem <= '0;
      r_cpl_rem   <= '0;
      r_tag_cnt   <= '0;
      r_out_tag   <= '0;
      r_cpl_flag  <= 1'b0;
      r_timer     <= '0;
      r_rq_valid  <= 1'b0;
      r_rq_addr   <= '0;
      r_rq_dw     <= '0;
      r_rq_tag    <= '0;
      r_rq_req_id <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_keep   <= '0;
      r_rd_last   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_next_addr <= w_next_addr_nxt;
      r_total_rem <= w_total_rem_nxt;
      r_cpl_rem   <= w_cpl_rem_nxt;
      r_tag_cnt   <= w_tag_cnt_nxt;
      r_out_tag   <= w_out_tag_nxt;
      r_cpl_flag  <= w_cpl_flag_nxt;
      r_timer     <= w_timer_nxt;
      r_rq_valid  <= w_rq_valid_nxt;
      r_rq_addr   <= w_rq_addr_nxt;
      r_rq_dw     <= w_rq_dw_nxt;
      r_rq_tag    <= w_rq_tag_nxt;
      r_rq_req_id <= w_rq_req_id_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_keep   <= w_rd_keep_nxt;
      r_rd_last   <= w_rd_last_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign io_bus.cmd_ready       = w_cmd_ready;
  assign io_bus.rq_valid        = r_rq_valid;
  assign io_bus.rq_is_write     = 1'b0;
  assign io_bus.rq_is_read      = r_rq_valid;
  assign io_bus.rq_sop          = r_rq_valid;
  assign io_bus.rq_last         = r_rq_valid;
  assign io_bus.rq_addr         = r_rq_addr;
  assign io_bus.rq_dword_count  = r_rq_dw;
  assign io_bus.rq_tag          = r_rq_tag;
  assign io_bus.rq_requester_id = r_rq_req_id;
  assign io_bus.rq_tc           = 3'd0;
  assign io_bus.rq_attr         = 3'd0;
  assign io_bus.rq_payload      = '0;
  assign io_bus.rq_payload_keep = '0;
  assign io_bus.rd_data_valid   = r_rd_valid;
  assign io_bus.rd_data         = r_rd_data;
  assign io_bus.rd_data_keep    = r_rd_keep;
  assign io_bus.rd_data_last    = r_rd_last;
  assign io_bus.done            = r_done;
  assign io_bus.err_code        = r_err;
  assign io_bus.busy            = (r_state != StIdle);

  // Length is tracked from keep; sop is implied by rc_desc_valid.
  assign w_unused = ^{io_bus.rc_dword_count, io_bus.rc_data_sop};
endmodule
